// File: rtl/io_spi_target.sv
// io_spi_target: SPI mode-0 target with RX/TX byte FIFOs on the dma_io bus and a daisy-chained read port.
// Define SPIS_FRAME_IRQ_EN to add the sticky frame_done flag and the frame-end interrupt source.
module io_spi_target #(
  parameter logic [13:0] BASE_ADR   = 14'h3200,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic        spis_sck,
  input  logic        spis_csn,
  input  logic        spis_mosi,
  output logic        spis_miso,
  output logic        spis_miso_en,
  output logic        spis_interrupt_1shot
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [1:0] sck_s, csn_s, mosi_s;
  logic sck_h, csn_h, sck_rise, sck_fall, csn_rise, csn_fall;
  logic enable, rx_irq_en, flush, frame_irq_en, frame_done, frame_irq;
  logic rx_overrun, tx_underrun;
  logic [7:0] shifter, tx_load, tx_head, rx_head;
  logic [2:0] bitcnt;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_cnt, rx_cnt;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic start, frame_end, shift_en, byte_done;
  logic tx_pop_req, tx_pop, tx_push, rx_push, rx_pop;
  logic wr_tx, wr_st, wr_ctl, rd_hit, hit_q;
  logic [13:0] roff;
  logic [31:0] status, control, rxdata, rd_data, rdata_q;
  logic [23:0] unused_wdata;
  assign unused_wdata = dma_io_wdata[31:8];
  assign sck_rise = sck_s[1] & ~sck_h;
  assign sck_fall = ~sck_s[1] & sck_h;
  assign csn_rise = csn_s[1] & ~csn_h;
  assign csn_fall = ~csn_s[1] & csn_h;
  assign spis_miso_en = ~csn_s[1] & enable;
  // csn synchronizer idles high so the bus is not seen as busy out of reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      sck_s  <= 2'b00;
      csn_s  <= 2'b11;
      mosi_s <= 2'b00;
      sck_h  <= 1'b0;
      csn_h  <= 1'b1;
    end else begin
      sck_s  <= {sck_s[0], spis_sck};
      csn_s  <= {csn_s[0], spis_csn};
      mosi_s <= {mosi_s[0], spis_mosi};
      sck_h  <= sck_s[1];
      csn_h  <= csn_s[1];
    end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    start     = enable && state_q == IDLE && csn_fall;
    frame_end = enable && state_q == SHIFT && csn_rise;
    shift_en  = enable && state_q == SHIFT && !csn_rise && sck_rise;
    state_d   = !enable ? IDLE : start ? SHIFT : frame_end ? IDLE : state_q;
  end
  assign byte_done  = shift_en && bitcnt == 3'd7;
  assign tx_pop_req = start || byte_done;
  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_empty = tx_wp == tx_rp;
  assign rx_empty = rx_wp == rx_rp;
  assign tx_full  = tx_cnt == FULL;
  assign rx_full  = rx_cnt == FULL;
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];
  assign tx_load  = tx_empty ? 8'hFF : tx_head;
  assign wr_tx  = dma_io_we && dma_io_wadr == BASE_ADR;
  assign wr_st  = dma_io_we && dma_io_wadr == BASE_ADR + 14'd2;
  assign wr_ctl = dma_io_we && dma_io_wadr == BASE_ADR + 14'd3;
  assign roff   = dma_io_radr - BASE_ADR;
  assign rd_hit = dma_io_radr_en && roff < 14'd4;
  // A same-cycle pop frees the slot a full FIFO would otherwise refuse
  assign rx_pop  = rd_hit && roff[1:0] == 2'd1 && !rx_empty;
  assign tx_pop  = tx_pop_req && !tx_empty;
  assign tx_push = wr_tx && (!tx_full || tx_pop);
  assign rx_push = byte_done && (!rx_full || rx_pop);
  always_ff @(posedge clk)
    if (!rst_n) begin
      shifter   <= 8'h00;
      bitcnt    <= 3'd0;
      spis_miso <= 1'b1;
    end else begin
      shifter   <= tx_pop_req ? tx_load : shift_en ? {shifter[6:0], mosi_s[1]} : shifter;
      bitcnt    <= start ? 3'd0 : shift_en ? bitcnt + 3'd1 : bitcnt;
      spis_miso <= start ? tx_load[7] : (state_q == SHIFT && sck_fall) ? shifter[7] : spis_miso;
    end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= dma_io_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= {shifter[6:0], mosi_s[1]};
  end
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      tx_wp <= tx_push ? tx_wp + ONE : tx_wp;
      tx_rp <= tx_pop ? tx_rp + ONE : tx_rp;
      rx_wp <= rx_push ? rx_wp + ONE : rx_wp;
      rx_rp <= rx_pop ? rx_rp + ONE : rx_rp;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      enable               <= 1'b0;
      rx_irq_en            <= 1'b0;
      flush                <= 1'b0;
      rx_overrun           <= 1'b0;
      tx_underrun          <= 1'b0;
      spis_interrupt_1shot <= 1'b0;
    end else begin
      enable               <= wr_ctl ? dma_io_wdata[0] : enable;
      rx_irq_en            <= wr_ctl ? dma_io_wdata[1] : rx_irq_en;
      flush                <= wr_ctl && dma_io_wdata[2];
      rx_overrun           <= (rx_overrun && !(wr_st && dma_io_wdata[3])) || (byte_done && !rx_push);
      tx_underrun          <= (tx_underrun && !(wr_st && dma_io_wdata[4])) || (tx_pop_req && tx_empty);
      spis_interrupt_1shot <= (rx_push && rx_irq_en) || frame_irq;
    end
`ifdef SPIS_FRAME_IRQ_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      frame_irq_en <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_irq_en <= wr_ctl ? dma_io_wdata[3] : frame_irq_en;
      frame_done   <= (frame_done && !(wr_st && dma_io_wdata[6])) || frame_end;
    end
  assign frame_irq = frame_end && frame_irq_en;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
  assign frame_irq_en = 1'b0;
  assign frame_done   = 1'b0;
  assign frame_irq    = 1'b0;
`endif
  assign status  = {16'd0, 4'(tx_cnt), 4'(rx_cnt), 1'b0, frame_done, ~csn_s[1], tx_underrun,
                    rx_overrun, tx_empty, tx_full, ~rx_empty};
  assign control = {28'd0, frame_irq_en, flush, rx_irq_en, enable};
  assign rxdata  = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
  always_comb
    rd_data = roff[1:0] == 2'd0 ? 32'd0 : roff[1:0] == 2'd1 ? rxdata : roff[1:0] == 2'd2 ? status : control;
  always_ff @(posedge clk)
    if (!rst_n) begin
      hit_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      hit_q   <= rd_hit;
      rdata_q <= rd_hit ? rd_data : rdata_q;
    end
  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;
endmodule
